mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store front end of the MIPS MEM stage. Sits between the EX/MEM pipeline register and Data_Memory.
- Converts byte addresses into word indexes and drives the Data_Memory write-enable and read-enable codes.
- Performs read-modify-write for sub-word stores at non-zero byte offsets, because Data_Memory writes sub-words only into the low lanes of a word.
- Aligns, sign-extends or zero-extends load data, and stalls the pipeline while a multi-cycle access is in progress.

Parameters:
- RAM_WIDTH, 32, data width of the memory and pipeline.
- NB_DEPTH, 10, Data_Memory word-address width.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_valid  in  1  EX/MEM request present; held by upstream while o_stall=1.
- i_load  in  1  request is a load.
- i_store  in  1  request is a store.
- i_size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is reserved.
- i_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-justified.
- o_stall  out  1  unit busy; the pipeline must freeze.
- o_rvalid  out  1  one-cycle pulse; o_rdata is valid.
- o_rdata  out  32  extended load result.
- o_fault  out  1  one-cycle pulse for misaligned, reserved-size or load+store requests.
- o_mem_addr  out  NB_DEPTH  word index, i_addr[NB_DEPTH+1:2]; upper bits are ignored, so addresses wrap.
- o_mem_data  out  32  write data to Data_Memory.
- o_mem_we  out  2  write code: 00 disable, 01 byte, 10 halfword, 11 word.
- o_mem_re  out  2  read code: 00 disable, 01 byte, 10 halfword, 11 word.
- i_mem_data  in  32  Data_Memory read data, valid the cycle after o_mem_re != 00.

Behaviour:
- Reset (i_rst=0 at an edge):
  - State goes to IDLE; all outputs go to 0 (o_mem_we=o_mem_re=00).
  - Any pending read-modify-write is aborted and no memory write occurs.
- Acceptance: a request is accepted when i_valid=1 and state=IDLE; this cycle is T. Requests are ignored in every other state. o_stall = (state != IDLE).
- Fault checks at T, in priority order:
  1. i_load=i_store=1, or i_size=11.
  2. Halfword access with addr[0]=1.
  3. Word access with addr[1:0]!=0.
- Fault handling: o_fault pulses in T+1; no memory access occurs; state stays IDLE; no stall.
- i_valid=1 with i_load=i_store=0 is a no-op.
- Load:
  - At T: o_mem_re=11 (always a word read); state goes to LD_WAIT and latches offset, size and unsigned.
  - In T+1 (o_stall=1): shift i_mem_data right by 8*offset, truncate to the access size, extend, and register the result.
  - In T+2: o_rvalid=1 with o_rdata set; state is IDLE, so a new request may be accepted in T+2.
- Direct store (word, or sub-word at offset 0):
  - At T: o_mem_we = 11, 10 or 01 as appropriate, with o_mem_data = i_wdata.
  - Completes in one cycle with no stall.
- Read-modify-write store (byte at offset 1-3, or halfword at offset 2):
  - At T: o_mem_re=11; state goes to RMW_RD.
  - In T+1: merge the i_wdata lane into i_mem_data at the offset and register the merged word; state goes to RMW_WR.
  - In T+2: o_mem_we=11 with the merged word; state goes to IDLE.
  - Stall lasts 2 cycles (T+1, T+2).
- o_mem_re and o_mem_we are 00 in every cycle not listed above. Both are never non-zero in the same cycle.
- States: IDLE, LD_WAIT, RMW_RD, RMW_WR.

Decomposition:
- Shared include file holds the constants: WRITE_DISABLE/BYTE/HALFWORD/WORD, READ_DISABLE/BYTE/HALFWORD/WORD, BYTE=8, HALFWORD=16, WORD=32, size codes, and FSM state codes.
- One sub-module, load_align_ext: combinational shift, truncate and sign/zero extension of the read word by offset, size and unsigned.

Test Plan:
- SW 0x80F1A2B3 to 0x3C0 -> o_mem_we=11 and o_mem_addr=0x0F0 in T; no stall; memory word = 0x80F1A2B3.
- LB at 0x3C3 (signed) -> o_stall in T+1; o_rvalid in T+2 with o_rdata=0xFFFFFF80. LBU at 0x3C0 -> 0x000000B3. LH at 0x3C2 (signed) -> 0xFFFF80F1.
- SB 0x55 to 0x3C1 -> o_stall for 2 cycles; o_mem_we=11 in T+2 with data 0x80F155B3; a following LW returns 0x80F155B3.
- SH to 0x3C1, and LW to 0x3C2 -> o_fault pulse; no o_mem_we/o_mem_re activity; no stall; memory unchanged.
- SB 0x11 to 0x3C2, with i_rst=0 asserted in T+1 -> IDLE; no write in T+2; all outputs 0; memory still 0x80F155B3.
- Back-to-back LW 0x3C0 then SW 0x3C4 held under stall -> the SW is accepted in T+2, after o_rvalid, and exactly one write occurs.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, state encoding and the store lane-merge helper
// for the MEM-stage load/store front end.
package mem_access_unit_pkg;

  localparam logic [1:0] WRITE_DISABLE  = 2'b00;
  localparam logic [1:0] WRITE_BYTE     = 2'b01;
  localparam logic [1:0] WRITE_HALFWORD = 2'b10;
  localparam logic [1:0] WRITE_WORD     = 2'b11;

  localparam logic [1:0] READ_DISABLE  = 2'b00;
  localparam logic [1:0] READ_BYTE     = 2'b01;
  localparam logic [1:0] READ_HALFWORD = 2'b10;
  localparam logic [1:0] READ_WORD     = 2'b11;

  localparam int BYTE     = 8;
  localparam int HALFWORD = 16;
  localparam int WORD     = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LD_WAIT = 2'b01,
    RMW_RD  = 2'b10,
    RMW_WR  = 2'b11
  } state_e;

  function automatic logic [WORD-1:0] merge_lane(
    input logic [WORD-1:0]     word,
    input logic [HALFWORD-1:0] wd,
    input logic [1:0]          off,
    input logic [1:0]          size
  );
    logic [WORD-1:0] mask;
    logic [WORD-1:0] lane;
    if (size == SIZE_BYTE) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      lane = {24'b0, wd[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off, 3'b000};
      lane = {16'b0, wd} << {off, 3'b000};
    end
    return (word & ~mask) | lane;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align_ext.sv
// Load data alignment: shift the read word down by the byte offset,
// truncate to the access size, then sign- or zero-extend.
module load_align_ext
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_WIDTH = 32
) (
  input  logic [RAM_WIDTH-1:0] i_word,
  input  logic [1:0]           i_off,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  output logic [RAM_WIDTH-1:0] o_data
);

  logic [RAM_WIDTH-1:0] shifted;
  logic                 sb;
  logic                 sh;

  assign shifted = i_word >> {i_off, 3'b000};
  assign sb      = ~i_unsigned & shifted[BYTE-1];
  assign sh      = ~i_unsigned & shifted[HALFWORD-1];

  always_comb begin
    o_data = shifted;
    case (i_size)
      SIZE_BYTE:
        o_data = {{(RAM_WIDTH-BYTE){sb}}, shifted[BYTE-1:0]};
      SIZE_HALF:
        o_data = {{(RAM_WIDTH-HALFWORD){sh}}, shifted[HALFWORD-1:0]};
      default:
        o_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end: word addressing, sub-word store
// read-modify-write, load alignment and pipeline stall.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int NB_DEPTH  = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_load,
  input  logic                 i_store,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [31:0]          i_addr,
  input  logic [RAM_WIDTH-1:0] i_wdata,
  output logic                 o_stall,
  output logic                 o_rvalid,
  output logic [RAM_WIDTH-1:0] o_rdata,
  output logic                 o_fault,
  output logic [NB_DEPTH-1:0]  o_mem_addr,
  output logic [RAM_WIDTH-1:0] o_mem_data,
  output logic [1:0]           o_mem_we,
  output logic [1:0]           o_mem_re,
  input  logic [RAM_WIDTH-1:0] i_mem_data
);

  state_e               state_q, state_d;
  logic [1:0]           off_q, off_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [NB_DEPTH-1:0]  addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [RAM_WIDTH-1:0] merged_q, merged_d;
  logic [RAM_WIDTH-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 fault_q, fault_d;

  logic                 accept;
  logic                 bad;
  logic                 direct;
  logic [RAM_WIDTH-1:0] ld_word;
  logic                 addr_unused;

  assign addr_unused = ^i_addr[31:NB_DEPTH+2];

  assign accept = i_rst & i_valid & (state_q == IDLE);

  assign bad = (i_load & i_store)
             | (i_size == SIZE_RSVD)
             | ((i_size == SIZE_HALF) & i_addr[0])
             | ((i_size == SIZE_WORD) & (|i_addr[1:0]));

  assign direct = (i_size == SIZE_WORD) | (i_addr[1:0] == 2'b00);

  load_align_ext #(
    .RAM_WIDTH (RAM_WIDTH)
  ) u_align (
    .i_word     (i_mem_data),
    .i_off      (off_q),
    .i_size     (size_q),
    .i_unsigned (uns_q),
    .o_data     (ld_word)
  );

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merged_d   = merged_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    fault_d    = 1'b0;
    o_mem_we   = WRITE_DISABLE;
    o_mem_re   = READ_DISABLE;
    o_mem_addr = addr_q;
    o_mem_data = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && (i_load || i_store)) begin
          o_mem_addr = i_addr[NB_DEPTH+1:2];
          off_d      = i_addr[1:0];
          size_d     = i_size;
          uns_d      = i_unsigned;
          addr_d     = i_addr[NB_DEPTH+1:2];
          wdata_d    = i_wdata[15:0];
          if (bad) begin
            fault_d = 1'b1;
          end else if (i_load) begin
            o_mem_re = READ_WORD;
            state_d  = LD_WAIT;
          end else if (direct) begin
            o_mem_data = i_wdata;
            o_mem_we   = (i_size == SIZE_WORD) ? WRITE_WORD :
                         (i_size == SIZE_HALF) ? WRITE_HALFWORD :
                                                 WRITE_BYTE;
          end else begin
            o_mem_re = READ_WORD;
            state_d  = RMW_RD;
          end
        end
      end
      LD_WAIT: begin
        rdata_d  = ld_word;
        rvalid_d = 1'b1;
        state_d  = IDLE;
      end
      RMW_RD: begin
        merged_d = merge_lane(i_mem_data, wdata_q, off_q, size_q);
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        o_mem_we   = WRITE_WORD;
        o_mem_data = merged_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Hold the memory port quiet while reset is asserted
    if (!i_rst) begin
      o_mem_we   = WRITE_DISABLE;
      o_mem_re   = READ_DISABLE;
      o_mem_addr = '0;
      o_mem_data = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fault_q  <= fault_d;
    end
  end

  assign o_stall  = i_rst & (state_q != IDLE);
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_fault  = fault_q;

endmodule
